// File: rtl/e_mdu_ctrl.sv
// Execute-stage multiply/divide controller: owns HI/LO, models MDU latency with a busy counter.
// Optional madd/maddu/msub/msubu support is enabled by defining MDU_MADD_EN.
module e_mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HIWrite,
  input  logic        LOWrite,
  input  logic [31:0] WData,
  input  logic        ReqMDU,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] MULT_N   = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N    = CNT_W'(DIV_CYCLES);

  state_t           state_r, nextState_s;
  logic [CNT_W-1:0] cnt_r, nextCnt_s;
  logic [31:0]      hi_r, lo_r, pendHi_r, pendLo_r;
  logic             wbEn_r;

  logic             isDiv_s, opValid_s, accept_s, lastCycle_s, divZero_s, divOvf_s;
  logic [63:0]      prodS_s, prodU_s, prod_s, result_s;
  logic [31:0]      divisor_s, quot_s, rem_s;

  // Operand arithmetic: both products and the guarded quotient/remainder.
  always_comb begin
    prodS_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prodU_s   = {32'h0000_0000, A} * {32'h0000_0000, B};
    prod_s    = MDUOp[0] ? prodU_s : prodS_s;
    divZero_s = (B == 32'h0000_0000);
    divOvf_s  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF) && !MDUOp[0];
    // A zero divisor is replaced so the divider never sees it; the result is discarded anyway.
    divisor_s = divZero_s ? 32'h0000_0001 : B;
    if (divOvf_s) begin
      quot_s = 32'h8000_0000;
      rem_s  = 32'h0000_0000;
    end else if (MDUOp[0]) begin
      quot_s = A / divisor_s;
      rem_s  = A % divisor_s;
    end else begin
      quot_s = $signed(A) / $signed(divisor_s);
      rem_s  = $signed(A) % $signed(divisor_s);
    end
  end

  // Select the pending {HI,LO} value for the requested operation.
  always_comb begin
    case (MDUOp[2:1])
      2'b00:   result_s = prod_s;
      2'b01:   result_s = {rem_s, quot_s};
`ifdef MDU_MADD_EN
      2'b10:   result_s = {hi_r, lo_r} + prod_s;
      2'b11:   result_s = {hi_r, lo_r} - prod_s;
`else
      2'b10:   result_s = {hi_r, lo_r};
      2'b11:   result_s = {hi_r, lo_r};
`endif
      default: result_s = {hi_r, lo_r};
    endcase
  end

  // Start acceptance decode.
  always_comb begin
    isDiv_s     = (MDUOp[2:1] == 2'b01);
`ifdef MDU_MADD_EN
    opValid_s   = 1'b1;
`else
    opValid_s   = !MDUOp[2];
`endif
    accept_s    = Start && (state_r == IDLE) && opValid_s;
    lastCycle_s = (state_r == RUN) && (cnt_r == CNT_ONE);
  end

  // Next-state and busy counter logic.
  always_comb begin
    nextState_s = state_r;
    nextCnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          nextState_s = RUN;
          nextCnt_s   = isDiv_s ? DIV_N : MULT_N;
        end else begin
          nextState_s = IDLE;
          nextCnt_s   = CNT_ZERO;
        end
      end
      RUN: begin
        if (cnt_r == CNT_ONE) begin
          nextState_s = IDLE;
          nextCnt_s   = CNT_ZERO;
        end else begin
          nextState_s = RUN;
          nextCnt_s   = cnt_r - CNT_ONE;
        end
      end
      default: begin
        nextState_s = IDLE;
        nextCnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, pending result and architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= CNT_ZERO;
      pendHi_r <= 32'h0000_0000;
      pendLo_r <= 32'h0000_0000;
      wbEn_r   <= 1'b0;
      hi_r     <= 32'h0000_0000;
      lo_r     <= 32'h0000_0000;
    end else begin
      state_r <= nextState_s;
      cnt_r   <= nextCnt_s;
      if (accept_s) begin
        pendHi_r <= result_s[63:32];
        pendLo_r <= result_s[31:0];
        wbEn_r   <= !(isDiv_s && divZero_s);
      end
      if (lastCycle_s) begin
        if (wbEn_r) begin
          hi_r <= pendHi_r;
          lo_r <= pendLo_r;
        end
      end else if ((state_r == IDLE) && !Start) begin
        if (HIWrite) begin
          hi_r <= WData;
        end
        if (LOWrite) begin
          lo_r <= WData;
        end
      end
    end
  end

  assign Busy  = (state_r == RUN);
  assign Stall = ReqMDU & (Start | Busy);
  assign HI    = hi_r;
  assign LO    = lo_r;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Self-checking bench for e_mdu_ctrl: directed cases plus random ops against an arithmetic model.
// Honors MDU_MADD_EN the same way as the design.
module tb_e_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset, Start, HIWrite, LOWrite, ReqMDU;
  logic [2:0]  MDUOp;
  logic [31:0] A, B, WData;
  logic        Busy, Stall;
  logic [31:0] HI, LO;

  int          cmpCnt = 0;
  int          errCnt = 0;
  logic [31:0] mHi, mLo;

  e_mdu_ctrl dut (
    .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp), .A(A), .B(B),
    .HIWrite(HIWrite), .LOWrite(LOWrite), .WData(WData), .ReqMDU(ReqMDU),
    .Busy(Busy), .Stall(Stall), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmpCnt++;
    assert (obs === exp) else begin
      errCnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: architectural effect of one MDU op on mHi/mLo and its busy length.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cycles);
    longint      sa, sb;
    logic [63:0] ua, ub, r64, q64, acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    cycles = 0;
    case (op)
      3'd0: begin r64 = sa * sb; {mHi, mLo} = r64; cycles = 5; end
      3'd1: begin r64 = ua * ub; {mHi, mLo} = r64; cycles = 5; end
      3'd2: begin
        cycles = 10;
        if (b != 32'h0) begin
          q64 = sa / sb; r64 = sa % sb;
          mLo = q64[31:0]; mHi = r64[31:0];
        end
      end
      3'd3: begin
        cycles = 10;
        if (b != 32'h0) begin
          q64 = ua / ub; r64 = ua % ub;
          mLo = q64[31:0]; mHi = r64[31:0];
        end
      end
      default: begin
`ifdef MDU_MADD_EN
        cycles = 5;
        if (op[0]) r64 = ua * ub;
        else       r64 = sa * sb;
        acc = {mHi, mLo};
        if (op[1]) acc = acc - r64;
        else       acc = acc + r64;
        {mHi, mLo} = acc;
`else
        cycles = 0;
`endif
      end
    endcase
  endtask

  // One op: optional mthi alongside Start (must be dropped) and optional illegal pokes while busy.
  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic req, input logic hw, input logic poke);
    int expCyc;
    int n;
    @(negedge clk);
    Start = 1'b1; MDUOp = op; A = a; B = b; ReqMDU = req;
    HIWrite = hw; WData = 32'hDEAD_BEEF;
    #1;
    chk({tag, " stall@start"}, 32'(Stall), 32'(req));
    model(op, a, b, expCyc);
    @(negedge clk);
    Start = 1'b0; HIWrite = 1'b0;
    #1;
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      if (req) chk({tag, " stall@busy"}, 32'(Stall), 32'd1);
      n++;
      @(negedge clk);
      if (poke && n == 1) begin
        Start = 1'b1; MDUOp = 3'd1; A = 32'h7; B = 32'h9;
        LOWrite = 1'b1; WData = 32'hBAD0_BAD0;
      end else begin
        Start = 1'b0; LOWrite = 1'b0;
      end
      #1;
    end
    chk({tag, " busy cycles"}, 32'(n), 32'(expCyc));
    chk({tag, " HI"}, HI, mHi);
    chk({tag, " LO"}, LO, mLo);
    chk({tag, " stall after"}, 32'(Stall), 32'd0);
    ReqMDU = 1'b0;
  endtask

  task automatic mtx(input string tag, input logic hw, input logic lw, input logic [31:0] d);
    @(negedge clk);
    HIWrite = hw; LOWrite = lw; WData = d;
    @(negedge clk);
    HIWrite = 1'b0; LOWrite = 1'b0;
    if (hw) mHi = d;
    if (lw) mLo = d;
    chk({tag, " HI"}, HI, mHi);
    chk({tag, " LO"}, LO, mLo);
    chk({tag, " busy"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          sel;

    reset = 1'b1; Start = 1'b0; MDUOp = 3'd0; A = 32'h0; B = 32'h0;
    HIWrite = 1'b0; LOWrite = 1'b0; WData = 32'h0; ReqMDU = 1'b0;
    mHi = 32'h0; mLo = 32'h0;
    repeat (3) @(negedge clk);
    ReqMDU = 1'b1;
    #1;
    chk("reset busy", 32'(Busy), 32'd0);
    chk("reset stall", 32'(Stall), 32'd0);
    chk("reset HI", HI, 32'h0);
    chk("reset LO", LO, 32'h0);
    ReqMDU = 1'b0;
    reset = 1'b0;

    runOp("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 1'b0);
    chk("mult HI const", HI, 32'hFFFF_FFFF);
    chk("mult LO const", LO, 32'hFFFF_FFFA);
    runOp("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 1'b0);
    chk("multu HI const", HI, 32'h0000_0002);
    chk("multu LO const", LO, 32'hFFFF_FFFA);
    runOp("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0);
    chk("div LO const", LO, 32'hFFFF_FFFD);
    chk("div HI const", HI, 32'hFFFF_FFFF);
    runOp("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    chk("div ovf LO const", LO, 32'h8000_0000);
    chk("div ovf HI const", HI, 32'h0);

    mtx("mthi", 1'b1, 1'b0, 32'h11);
    mtx("mtlo", 1'b0, 1'b1, 32'h22);
    runOp("div0", 3'd2, 32'h1234, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("div0 HI const", HI, 32'h11);
    chk("div0 LO const", LO, 32'h22);

    mtx("mtlo1234", 1'b0, 1'b1, 32'h1234);
    chk("mtlo LO const", LO, 32'h1234);
    runOp("start+mthi", 3'd0, 32'd6, 32'd7, 1'b1, 1'b1, 1'b0);
    runOp("poke busy", 3'd3, 32'd100, 32'd7, 1'b1, 1'b0, 1'b1);

`ifdef MDU_MADD_EN
    mtx("pre madd", 1'b1, 1'b1, 32'h0);
    mtx("pre madd lo", 1'b0, 1'b1, 32'hFFFF_FFFF);
    runOp("madd", 3'd4, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0);
    chk("madd HI const", HI, 32'h1);
    chk("madd LO const", LO, 32'h0);
`else
    runOp("noop madd", 3'd4, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'h0;
      else if (sel == 1) rb = 32'($urandom_range(1, 9));
      else if (sel == 2) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      runOp("rand", rop, ra, rb, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    mtx("pre reset", 1'b1, 1'b1, 32'hAAAA);
    @(negedge clk);
    Start = 1'b1; MDUOp = 3'd2; A = 32'd100; B = 32'd7;
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mHi = 32'h0; mLo = 32'h0;
    chk("abort busy", 32'(Busy), 32'd0);
    chk("abort HI", HI, 32'h0);
    chk("abort LO", LO, 32'h0);
    repeat (12) @(negedge clk);
    chk("abort late busy", 32'(Busy), 32'd0);
    chk("abort late HI", HI, mHi);
    chk("abort late LO", LO, mLo);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

endmodule
